// File: rtl/lif_sched_pkg.sv
// Shared types and helpers for the LIF timestep scheduler.
// State encoding, memory-port select values and a spike-word popcount.
package lif_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYN_GO   = 3'd1,
        ST_SYN_REL  = 3'd2,
        ST_LIF_GO   = 3'd3,
        ST_LIF_REL  = 3'd4,
        ST_STEP_END = 3'd5,
        ST_DRAIN    = 3'd6,
        ST_FINISH   = 3'd7
    } sched_state_t;

    localparam logic SEL_SYN = 1'b0;
    localparam logic SEL_LIF = 1'b1;

    // Spike words up to this width are zero-extended before counting.
    localparam int POP_MAX_W = 64;

    function automatic logic [6:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lif_sched_watchdog.sv
// Per-phase watchdog: clearable up-counter that flags when it reaches a limit.
// Zero latency on the expiry compare; a limit of zero never expires.
module lif_sched_watchdog #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (limit != '0) && (cnt == limit);

endmodule

// File: rtl/lif_step_scheduler.sv
// Sequences synapse then LIF engines per timestep, owns the current-memory mux
// and reports per-step spike totals; abort/timeout drain engines before done.
module lif_step_scheduler
    import lif_sched_pkg::*;
#(
    parameter int ADDRW      = 12,
    parameter int PACK_WIDTH = 8,
    parameter int STEP_W     = 16,
    parameter int TMO_W      = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_run,
    input  logic [STEP_W-1:0]   i_num_steps,
    input  logic [TMO_W-1:0]    i_timeout,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err_timeout,
    output logic                o_aborted,
    output logic [STEP_W-1:0]   o_step_idx,
    output logic                o_syn_start,
    input  logic                i_syn_done,
    output logic                o_lif_start,
    input  logic                i_lif_done,
    input  logic                i_spike_valid,
    input  logic                i_spike_ready,
    input  logic [PACK_WIDTH-1:0] i_spike_data,
    output logic [ADDRW:0]      o_step_spikes,
    output logic                o_step_spikes_vld,
    input  logic [ADDRW-1:0]    i_syn_addr,
    input  logic                i_syn_we,
    input  logic [31:0]         i_syn_din,
    input  logic [ADDRW-1:0]    i_lif_addr,
    input  logic                i_lif_we,
    input  logic [31:0]         i_lif_din,
    output logic [ADDRW-1:0]    o_mem_addr,
    output logic                o_mem_we,
    output logic [31:0]         o_mem_din
);

    localparam int            ACC_W   = ADDRW + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    sched_state_t        state, next_state;
    logic                run_q;
    logic [STEP_W-1:0]   num_steps_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W:0]      acc_sum;
    logic [POP_MAX_W-1:0] spike_ext;
    logic                run_rise, in_phase, in_lif, wd_expired, wd_load;
    logic                tmo_hit, abort_hit, beat;
    logic                sel;

    assign run_rise  = i_run && !run_q;
    assign in_phase  = (state == ST_SYN_GO) || (state == ST_SYN_REL) ||
                       (state == ST_LIF_GO) || (state == ST_LIF_REL);
    assign in_lif    = (state == ST_LIF_GO) || (state == ST_LIF_REL);
    assign tmo_hit   = in_phase && wd_expired;
    assign abort_hit = i_abort && (state != ST_IDLE) &&
                       (state != ST_DRAIN) && (state != ST_FINISH);
    assign beat      = in_lif && i_spike_valid && i_spike_ready;

    assign spike_ext = POP_MAX_W'(i_spike_data);
    assign acc_sum   = {1'b0, acc} + (ACC_W + 1)'(popcount(spike_ext));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (run_rise) next_state = (i_num_steps == '0) ? ST_FINISH : ST_SYN_GO;
            ST_SYN_GO:   if (i_syn_done) next_state = ST_SYN_REL;
            ST_SYN_REL:  if (!i_syn_done) next_state = ST_LIF_GO;
            ST_LIF_GO:   if (i_lif_done) next_state = ST_LIF_REL;
            ST_LIF_REL:  if (!i_lif_done) next_state = ST_STEP_END;
            ST_STEP_END: next_state = (o_step_idx == num_steps_q - STEP_W'(1)) ? ST_FINISH : ST_SYN_GO;
            ST_DRAIN:    if (!i_syn_done && !i_lif_done) next_state = ST_FINISH;
            ST_FINISH:   next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
        // Stop requests win over normal sequencing; the step report in STEP_END is registered regardless.
        if (tmo_hit || abort_hit) next_state = ST_DRAIN;
    end

    // Counter restarts whenever a new engine phase is entered.
    assign wd_load = (next_state != state) &&
                     ((next_state == ST_SYN_GO) || (next_state == ST_SYN_REL) ||
                      (next_state == ST_LIF_GO) || (next_state == ST_LIF_REL));

    lif_sched_watchdog #(.CNT_W(TMO_W)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wd_load),
        .en      (in_phase),
        .limit   (tmo_q),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            run_q             <= 1'b0;
            num_steps_q       <= '0;
            tmo_q             <= '0;
            o_step_idx        <= '0;
            o_err_timeout     <= 1'b0;
            o_aborted         <= 1'b0;
            acc               <= '0;
            o_step_spikes     <= '0;
            o_step_spikes_vld <= 1'b0;
        end else begin
            state             <= next_state;
            run_q             <= i_run;
            o_step_spikes_vld <= (state == ST_STEP_END);
            if (state == ST_IDLE && run_rise) begin
                num_steps_q   <= i_num_steps;
                tmo_q         <= i_timeout;
                o_step_idx    <= '0;
                o_err_timeout <= 1'b0;
                o_aborted     <= 1'b0;
            end
            if (tmo_hit) o_err_timeout <= 1'b1;
            if (abort_hit) o_aborted <= 1'b1;
            if (state == ST_STEP_END) begin
                o_step_spikes <= acc;
                if (next_state == ST_SYN_GO) o_step_idx <= o_step_idx + 1'b1;
            end
            if (next_state == ST_SYN_GO && state != ST_SYN_GO) begin
                acc <= '0;
            end else if (beat) begin
                acc <= (acc_sum > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum[ACC_W-1:0];
            end
        end
    end

    assign o_busy      = (state != ST_IDLE);
    assign o_done      = (state == ST_FINISH);
    assign o_syn_start = (state == ST_SYN_GO);
    assign o_lif_start = (state == ST_LIF_GO);

    assign sel        = in_lif ? SEL_LIF : SEL_SYN;
    assign o_mem_addr = (sel == SEL_LIF) ? i_lif_addr : i_syn_addr;
    assign o_mem_din  = (sel == SEL_LIF) ? i_lif_din  : i_syn_din;
    assign o_mem_we   = (sel == SEL_LIF) ? i_lif_we   : i_syn_we;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Bench for lif_step_scheduler: engine models, a monitor filling observation
// queues, and per-scenario tasks comparing against expected queues.
module tb_lif_step_scheduler;

    localparam int ADDRW = 12;
    localparam int PW    = 8;
    localparam int SW    = 16;
    localparam int TW    = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_run, i_abort;
    logic [SW-1:0]    i_num_steps;
    logic [TW-1:0]    i_timeout;
    logic             o_busy, o_done, o_err_timeout, o_aborted;
    logic [SW-1:0]    o_step_idx;
    logic             o_syn_start, i_syn_done, o_lif_start, i_lif_done;
    logic             i_spike_valid, i_spike_ready;
    logic [PW-1:0]    i_spike_data;
    logic [ADDRW:0]   o_step_spikes;
    logic             o_step_spikes_vld;
    logic [ADDRW-1:0] i_syn_addr, i_lif_addr, o_mem_addr;
    logic             i_syn_we, i_lif_we, o_mem_we;
    logic [31:0]      i_syn_din, i_lif_din, o_mem_din;

    int n_vec = 0;
    int n_err = 0;

    lif_step_scheduler #(.ADDRW(ADDRW), .PACK_WIDTH(PW), .STEP_W(SW), .TMO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_num_steps(i_num_steps),
        .i_timeout(i_timeout), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
        .o_err_timeout(o_err_timeout), .o_aborted(o_aborted), .o_step_idx(o_step_idx),
        .o_syn_start(o_syn_start), .i_syn_done(i_syn_done), .o_lif_start(o_lif_start),
        .i_lif_done(i_lif_done), .i_spike_valid(i_spike_valid), .i_spike_ready(i_spike_ready),
        .i_spike_data(i_spike_data), .o_step_spikes(o_step_spikes),
        .o_step_spikes_vld(o_step_spikes_vld), .i_syn_addr(i_syn_addr), .i_syn_we(i_syn_we),
        .i_syn_din(i_syn_din), .i_lif_addr(i_lif_addr), .i_lif_we(i_lif_we),
        .i_lif_din(i_lif_din), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
        .o_mem_din(o_mem_din)
    );

    always #5 clk = ~clk;

    // Engine models: raise done after a fixed latency while start is held, drop it once start falls.
    logic syn_hang = 1'b0;
    int   lif_lat  = 10;
    int   syn_cnt, lif_cnt;

    always @(posedge clk) begin
        if (!rst_n || !o_syn_start) begin
            syn_cnt    <= 0;
            i_syn_done <= 1'b0;
        end else if (!syn_hang) begin
            syn_cnt <= syn_cnt + 1;
            if (syn_cnt == 9) i_syn_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n || !o_lif_start) begin
            lif_cnt    <= 0;
            i_lif_done <= 1'b0;
        end else begin
            lif_cnt <= lif_cnt + 1;
            if (lif_cnt == lif_lat - 1) i_lif_done <= 1'b1;
        end
    end

    // Monitor: phase starts (1=syn, 2=lif), step index at each syn start, spike reports, dones.
    int   obs_ph[$];
    int   obs_idx[$];
    int   obs_spk[$];
    int   done_cnt = 0, vld_cnt = 0, syn_hi_cnt = 0;
    time  last_done_t = 0;
    logic prev_syn = 1'b0, prev_lif = 1'b0;

    always @(negedge clk) begin
        if (o_syn_start && !prev_syn) begin
            obs_ph.push_back(1);
            obs_idx.push_back(int'(o_step_idx));
        end
        if (o_lif_start && !prev_lif) obs_ph.push_back(2);
        if (o_syn_start) syn_hi_cnt++;
        if (o_step_spikes_vld) begin
            obs_spk.push_back(int'(o_step_spikes));
            vld_cnt++;
        end
        if (o_done) begin
            done_cnt++;
            last_done_t = $time;
        end
        prev_syn = o_syn_start;
        prev_lif = o_lif_start;
    end

    int exp_ph[$];
    int exp_idx[$];
    int exp_spk[$];
    int ph_rd = 0, idx_rd = 0, spk_rd = 0;

    task automatic sync_rd();
        ph_rd  = obs_ph.size();
        idx_rd = obs_idx.size();
        spk_rd = obs_spk.size();
        exp_ph.delete();
        exp_idx.delete();
        exp_spk.delete();
    endtask

    task automatic run_start(input int steps, input int tmo);
        @(negedge clk);
        i_num_steps = SW'(steps);
        i_timeout   = TW'(tmo);
        i_run       = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
    endtask

    task automatic wait_done(input int base, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_sig(input int which, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((which == 1 && o_syn_start) || (which == 2 && o_lif_start)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [127:0] outs;
        rst_n = 1'b0; i_run = 0; i_abort = 0; i_num_steps = '0; i_timeout = '0;
        i_spike_valid = 0; i_spike_ready = 0; i_spike_data = '0;
        i_syn_addr = '0; i_syn_we = 0; i_syn_din = '0;
        i_lif_addr = '0; i_lif_we = 0; i_lif_din = '0;
        repeat (3) @(negedge clk);
        outs = 128'({o_busy, o_done, o_err_timeout, o_aborted, o_step_idx, o_syn_start,
                     o_lif_start, o_step_spikes, o_step_spikes_vld, o_mem_addr, o_mem_we, o_mem_din});
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %h expected 0", outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle busy got %b expected 0", o_busy);
        end
    endtask

    task automatic test_three_steps();
        bit ok;
        int base_d = done_cnt, base_v = vld_cnt;
        sync_rd();
        for (int s = 0; s < 3; s++) begin
            exp_ph.push_back(1); exp_ph.push_back(2);
            exp_idx.push_back(s);
            exp_spk.push_back(0);
        end
        run_start(3, 0);
        wait_done(base_d, 500, ok);
        repeat (3) @(negedge clk);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL steps_done_timeout got none expected done"); end
        while (exp_ph.size() > 0) begin
            int e = exp_ph.pop_front();
            int o = (ph_rd < obs_ph.size()) ? obs_ph[ph_rd] : -1;
            ph_rd++;
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL steps_phase got %0d expected %0d", o, e); end
        end
        while (exp_idx.size() > 0) begin
            int e = exp_idx.pop_front();
            int o = (idx_rd < obs_idx.size()) ? obs_idx[idx_rd] : -1;
            idx_rd++;
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL steps_idx got %0d expected %0d", o, e); end
        end
        n_vec++;
        if (obs_ph.size() != ph_rd) begin
            n_err++; $display("FAIL steps_extra_phase got %0d expected %0d", obs_ph.size(), ph_rd);
        end
        n_vec++;
        if (done_cnt - base_d != 1) begin
            n_err++; $display("FAIL steps_done_count got %0d expected 1", done_cnt - base_d);
        end
        n_vec++;
        if (vld_cnt - base_v != 3) begin
            n_err++; $display("FAIL steps_vld_count got %0d expected 3", vld_cnt - base_v);
        end
        n_vec++;
        if (o_busy !== 1'b0) begin n_err++; $display("FAIL steps_busy_after got %b expected 0", o_busy); end
    endtask

    task automatic test_zero_steps();
        bit ok;
        int base_d = done_cnt, base_s = obs_ph.size();
        time t0;
        @(negedge clk);
        i_num_steps = '0; i_timeout = '0; i_run = 1'b1;
        t0 = $time;
        @(negedge clk);
        i_run = 1'b0;
        wait_done(base_d, 20, ok);
        repeat (3) @(negedge clk);
        n_vec++;
        if (!ok || (last_done_t - t0) < 10 || (last_done_t - t0) > 20) begin
            n_err++; $display("FAIL zero_done_latency got %0t expected 10..20", last_done_t - t0);
        end
        n_vec++;
        if (obs_ph.size() != base_s) begin
            n_err++; $display("FAIL zero_no_start got %0d starts expected 0", obs_ph.size() - base_s);
        end
        n_vec++;
        if (done_cnt - base_d != 1) begin
            n_err++; $display("FAIL zero_done_count got %0d expected 1", done_cnt - base_d);
        end
    endtask

    task automatic test_spikes();
        bit ok, ok2;
        int base_d = done_cnt, base_v = vld_cnt;
        logic [PW-1:0] dat [5] = '{8'hFF, 8'h01, 8'h01, 8'h80, 8'h00};
        logic          vv  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic          rr  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        sync_rd();
        exp_spk.push_back(10);
        run_start(1, 0);
        wait_sig(1, 20, ok);
        i_spike_valid = 1; i_spike_ready = 1; i_spike_data = 8'hFF;
        @(negedge clk);
        i_spike_valid = 0; i_spike_ready = 0;
        wait_sig(2, 50, ok2);
        for (int k = 0; k < 5; k++) begin
            i_spike_valid = vv[k]; i_spike_ready = rr[k]; i_spike_data = dat[k];
            @(negedge clk);
        end
        wait_done(base_d, 200, ok);
        repeat (2) @(negedge clk);
        n_vec++;
        if (!ok || !ok2) begin n_err++; $display("FAIL spikes_run got stall expected done"); end
        while (exp_spk.size() > 0) begin
            int e = exp_spk.pop_front();
            int o = (spk_rd < obs_spk.size()) ? obs_spk[spk_rd] : -1;
            spk_rd++;
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL spikes_total got %0d expected %0d", o, e); end
        end
        n_vec++;
        if (vld_cnt - base_v != 1) begin
            n_err++; $display("FAIL spikes_vld_count got %0d expected 1", vld_cnt - base_v);
        end
    endtask

    task automatic test_saturate();
        bit ok, ok2;
        int base_d = done_cnt;
        sync_rd();
        exp_spk.push_back((1 << (ADDRW + 1)) - 1);
        lif_lat = 1100;
        run_start(1, 0);
        wait_sig(2, 50, ok2);
        for (int k = 0; k < 1050; k++) begin
            i_spike_valid = 1; i_spike_ready = 1; i_spike_data = 8'hFF;
            @(negedge clk);
        end
        i_spike_valid = 0; i_spike_ready = 0;
        wait_done(base_d, 300, ok);
        lif_lat = 10;
        repeat (2) @(negedge clk);
        n_vec++;
        if (!ok || !ok2) begin n_err++; $display("FAIL sat_run got stall expected done"); end
        while (exp_spk.size() > 0) begin
            int e = exp_spk.pop_front();
            int o = (spk_rd < obs_spk.size()) ? obs_spk[spk_rd] : -1;
            spk_rd++;
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL sat_total got %0d expected %0d", o, e); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int base_d = done_cnt, base_h;
        syn_hang = 1'b1;
        base_h = syn_hi_cnt;
        run_start(5, 50);
        wait_done(base_d, 300, ok);
        @(negedge clk);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL tmo_done got none expected done"); end
        n_vec++;
        if (syn_hi_cnt - base_h != 51) begin
            n_err++; $display("FAIL tmo_syn_cycles got %0d expected 51", syn_hi_cnt - base_h);
        end
        n_vec++;
        if ({o_err_timeout, o_aborted} !== 2'b10) begin
            n_err++; $display("FAIL tmo_flags got %b expected 10", {o_err_timeout, o_aborted});
        end
        syn_hang = 1'b0;
        base_d = done_cnt;
        run_start(1, 0);
        wait_done(base_d, 200, ok);
        n_vec++;
        if (!ok || o_err_timeout !== 1'b0) begin
            n_err++; $display("FAIL tmo_clear got %b expected 0", o_err_timeout);
        end
    endtask

    task automatic test_abort();
        bit ok, hit;
        int base_d = done_cnt, base_v = vld_cnt;
        sync_rd();
        exp_ph.push_back(1); exp_ph.push_back(2); exp_ph.push_back(1); exp_ph.push_back(2);
        run_start(4, 0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (o_lif_start && o_step_idx == 1) hit = 1'b1;
        end
        repeat (3) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        n_vec++;
        if (!hit || o_lif_start !== 1'b0) begin
            n_err++; $display("FAIL abort_lif_drop got %b expected 0", o_lif_start);
        end
        wait_done(base_d, 100, ok);
        repeat (3) @(negedge clk);
        n_vec++;
        if (!ok || o_aborted !== 1'b1) begin
            n_err++; $display("FAIL abort_flag got %b expected 1", o_aborted);
        end
        while (exp_ph.size() > 0) begin
            int e = exp_ph.pop_front();
            int o = (ph_rd < obs_ph.size()) ? obs_ph[ph_rd] : -1;
            ph_rd++;
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL abort_phase got %0d expected %0d", o, e); end
        end
        n_vec++;
        if (vld_cnt - base_v != 1 || done_cnt - base_d != 1) begin
            n_err++; $display("FAIL abort_reports got vld=%0d done=%0d expected 1 1",
                              vld_cnt - base_v, done_cnt - base_d);
        end
    endtask

    task automatic test_mem_mux();
        bit ok, ok2;
        int base_d = done_cnt;
        i_syn_addr = 12'h005; i_syn_we = 1; i_syn_din = 32'hAAAA_0001;
        i_lif_addr = 12'h009; i_lif_we = 1; i_lif_din = 32'h5555_0002;
        run_start(1, 0);
        wait_sig(1, 20, ok);
        n_vec++;
        if (!ok || {o_mem_addr, o_mem_we, o_mem_din} !== {12'h005, 1'b1, 32'hAAAA_0001}) begin
            n_err++; $display("FAIL mux_syn got %h/%b/%h expected 005/1/aaaa0001", o_mem_addr, o_mem_we, o_mem_din);
        end
        i_syn_we = 0;
        wait_sig(2, 50, ok2);
        n_vec++;
        if (!ok2 || {o_mem_addr, o_mem_we, o_mem_din} !== {12'h009, 1'b1, 32'h5555_0002}) begin
            n_err++; $display("FAIL mux_lif got %h/%b/%h expected 009/1/55550002", o_mem_addr, o_mem_we, o_mem_din);
        end
        i_syn_we = 1; i_lif_we = 0;
        @(negedge clk);
        n_vec++;
        if (o_lif_start !== 1'b1 || o_mem_we !== 1'b0) begin
            n_err++; $display("FAIL mux_drop_syn_we got %b expected 0", o_mem_we);
        end
        i_syn_we = 0;
        wait_done(base_d, 200, ok);
    endtask

    task automatic test_mid_reset();
        bit ok;
        run_start(3, 0);
        wait_sig(2, 50, ok);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({o_busy, o_lif_start, o_syn_start, o_step_idx} !== '0) begin
            n_err++; $display("FAIL mid_reset got busy=%b lif=%b idx=%0d expected 0",
                              o_busy, o_lif_start, o_step_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_three_steps();
        test_zero_steps();
        test_spikes();
        test_saturate();
        test_timeout();
        test_abort();
        test_mem_mux();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
